// File: rtl/core_pkg.sv
// Shared RV32I control definitions: FSM states, instruction classes,
// opcode constants and datapath select encodings.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_OP      = 3'd0,
        CLS_OP_IMM  = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_JALR    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } iclass_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_SEL_PC4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM = 2'b01;
    localparam logic [1:0] PC_SEL_ALU = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Classes whose ALU second operand is the immediate.
    function automatic logic uses_imm_b(input iclass_e c);
        return (c == CLS_OP_IMM) || (c == CLS_LOAD) ||
               (c == CLS_STORE)  || (c == CLS_JALR);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps inst[6:0] to an instruction class and a legal flag.
module ctrl_decode
    import core_pkg::*;
(
    input  logic [6:0] i_opcode,
    output iclass_e    o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_OP:     o_class = CLS_OP;
            OPC_OP_IMM: o_class = CLS_OP_IMM;
            OPC_LOAD:   o_class = CLS_LOAD;
            OPC_STORE:  o_class = CLS_STORE;
            OPC_BRANCH: o_class = CLS_BRANCH;
            OPC_JAL:    o_class = CLS_JAL;
            OPC_JALR:   o_class = CLS_JALR;
            // LUI/AUIPC land here until U-type immediates are supported
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: instruction register, per-state
// datapath selects, memory handshakes and retired-instruction counter.
//
// state  | meaning
// IDLE   | one cycle after reset release, everything quiet
// FETCH  | imem_req high until imem_valid, captures inst
// DECODE | classify opcode, illegal opcodes go to HALT
// EXEC   | ALU operand selects; branches retire here
// MEM    | dmem_req high until dmem_valid; stores retire here
// WB     | register write (rd != 0), PC update, retire
// HALT   | terminal after an illegal opcode until reset
module ctrl_fsm
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_valid,
    input  logic        branch_taken,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic [31:0] instret,
    output logic        illegal
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_inst;
    logic [31:0] r_instret;
    logic        r_illegal;
    iclass_e     w_class;
    logic        w_legal;
    logic        w_pc_we;

    ctrl_decode u_decode (
        .i_opcode (r_inst[6:0]),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_FETCH;
            ST_FETCH:  if (imem_valid) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = w_legal ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                case (w_class)
                    CLS_LOAD, CLS_STORE:                    w_state_nxt = ST_MEM;
                    CLS_BRANCH:                             w_state_nxt = ST_FETCH;
                    CLS_OP, CLS_OP_IMM, CLS_JAL, CLS_JALR:  w_state_nxt = ST_WB;
                    default:                                w_state_nxt = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (dmem_valid) begin
                    w_state_nxt = (w_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   w_state_nxt = ST_FETCH;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        w_pc_we   = 1'b0;
        pc_sel    = PC_SEL_PC4;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        case (r_state)
            ST_FETCH: imem_req = 1'b1;
            ST_EXEC: begin
                alu_b_sel = uses_imm_b(w_class);
                if (w_class == CLS_BRANCH) begin
                    w_pc_we = 1'b1;
                    pc_sel  = branch_taken ? PC_SEL_IMM : PC_SEL_PC4;
                end else if (w_class == CLS_JAL) begin
                    pc_sel = PC_SEL_IMM;
                end
            end
            ST_MEM: begin
                alu_b_sel = uses_imm_b(w_class);
                dmem_req  = 1'b1;
                dmem_we   = (w_class == CLS_STORE);
                w_pc_we   = dmem_valid && (w_class == CLS_STORE);
            end
            ST_WB: begin
                alu_b_sel = uses_imm_b(w_class);
                rf_we     = (r_inst[11:7] != 5'd0);
                w_pc_we   = 1'b1;
                case (w_class)
                    CLS_LOAD: wb_sel = WB_SEL_LOAD;
                    CLS_JAL: begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_IMM;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_ALU;
                    end
                    default: begin
                        wb_sel = WB_SEL_ALU;
                        pc_sel = PC_SEL_PC4;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst    <= INST_NOP;
            r_instret <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == ST_FETCH && imem_valid) begin
                r_inst <= imem_rdata;
            end
            if (w_pc_we) begin
                r_instret <= r_instret + 32'd1;
            end
            if (r_state == ST_DECODE && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign pc_we   = w_pc_we;
    assign retire  = w_pc_we;
    assign inst    = r_inst;
    assign instret = r_instret;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed and randomized instructions
// against a per-instruction timing/select model derived from the ISA rules.
module tb_ctrl_fsm;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_valid = 1'b0;
    logic        branch_taken = 1'b0;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic [31:0] instret;
    logic        illegal;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_instret = 32'd0;

    ctrl_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_valid   (dmem_valid),
        .branch_taken (branch_taken),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .instret      (instret),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({imem_req, dmem_req, dmem_we, alu_a_sel, alu_b_sel,
                      pc_we, pc_sel, rf_we, wb_sel, retire}), 32'd0);
    endtask

    // Reference classification: 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, -1 illegal
    function automatic int kind_of(input logic [6:0] opc);
        case (opc)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            7'b1100111: return 6;
            default:    return -1;
        endcase
    endfunction

    // Drives one legal instruction from FETCH to retirement with the given
    // memory wait counts, then compares the observed behaviour to the model.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic bt);
        int   k      = kind_of(ins[6:0]);
        bit   is_mem = (k == 2) || (k == 3);
        int   e_lat  = ((k == 4) ? 3 : (k == 2) ? 5 : 4) + iw + (is_mem ? dw : 0);
        int   e_dreq = is_mem ? dw + 1 : 0;
        logic [1:0] e_pc = (k == 4) ? {1'b0, bt} : (k == 5) ? 2'd1 : (k == 6) ? 2'd2 : 2'd0;
        logic [1:0] e_wb = (k == 2) ? 2'd1 : (k == 5 || k == 6) ? 2'd2 : 2'd0;
        bit   e_wr   = (k == 0 || k == 1 || k == 2 || k == 5 || k == 6) && (ins[11:7] != 5'd0);
        bit   e_b    = (k == 1 || k == 2 || k == 3 || k == 6);
        int   cyc = 0, ireq = 0, dreq = 0, dwe = 0, rfw = 0, pcw = 0;
        bit   done = 0;
        logic [1:0]  ps = 2'd0, ws = 2'd0;
        logic        bsel = 1'b0, asel = 1'b0;
        logic [31:0] inst_dec = 32'd0, inst_ret = 32'd0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            imem_rdata   = ins;
            branch_taken = bt;
            imem_valid   = imem_req && (ireq == iw);
            dmem_valid   = dmem_req && (dreq == dw);
            #1;
            if (c == 0) chk("instret_before", instret, exp_instret);
            if (imem_req) ireq++;
            if (dmem_req) begin
                dreq++;
                if (dmem_we) dwe++;
            end
            if (rf_we) rfw++;
            if (pc_we) pcw++;
            if (c == iw + 1) inst_dec = inst;
            if (c == iw + 2) begin
                bsel = alu_b_sel;
                asel = alu_a_sel;
            end
            if (retire) begin
                done     = 1;
                cyc      = c + 1;
                ps       = pc_sel;
                ws       = wb_sel;
                inst_ret = inst;
            end
        end
        chk("retired_in_budget", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'(e_lat));
        chk("imem_req_cycles", 32'(ireq), 32'(iw + 1));
        chk("dmem_req_cycles", 32'(dreq), 32'(e_dreq));
        chk("dmem_we_cycles", 32'(dwe), (k == 3) ? 32'(e_dreq) : 32'd0);
        chk("rf_we_cycles", 32'(rfw), 32'(e_wr));
        chk("pc_we_cycles", 32'(pcw), 32'd1);
        chk("pc_sel_at_retire", 32'(ps), 32'(e_pc));
        if (e_wr) chk("wb_sel_at_retire", 32'(ws), 32'(e_wb));
        chk("alu_b_sel_exec", 32'(bsel), 32'(e_b));
        chk("alu_a_sel_exec", 32'(asel), 32'd0);
        chk("inst_decode", inst_dec, ins);
        chk("inst_retire", inst_ret, ins);
        exp_instret = exp_instret + 32'd1;
    endtask

    initial begin
        logic [6:0]  opcs [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111};
        logic [31:0] r;
        bit          seen;
        int          nreq;

        repeat (3) @(negedge clk);
        #1;
        chk_quiet("reset_outputs");
        chk("reset_inst", inst, 32'h0000_0013);
        chk("reset_instret", instret, 32'd0);
        chk("reset_illegal", 32'(illegal), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("idle_outputs");

        run_instr(32'h0050_0093, 0, 0, 1'b0);   // addi x1,x0,5
        run_instr(32'h0000_A103, 0, 3, 1'b0);   // lw x2,0(x1), slow dmem
        run_instr(32'h0020_A223, 0, 0, 1'b0);   // sw x2,4(x1)
        run_instr(32'h0000_0463, 0, 0, 1'b1);   // beq taken
        run_instr(32'h0000_0463, 0, 0, 1'b0);   // beq not taken
        run_instr(32'h0080_00EF, 0, 0, 1'b0);   // jal x1,8
        run_instr(32'h0000_8067, 0, 0, 1'b0);   // jalr x0,0(x1)
        run_instr(32'h0050_0093, 2, 0, 1'b0);   // slow imem

        for (int i = 0; i < 40; i++) begin
            r        = $urandom;
            r[11:7]  = 5'($urandom_range(0, 3));
            r[6:0]   = opcs[$urandom_range(0, 6)];
            run_instr(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Counter wrap
        @(posedge clk);
        #1;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        exp_instret = 32'hFFFF_FFFF;
        run_instr(32'h0010_0113, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        chk("instret_wrap", instret, 32'd0);

        // Reset while in WB suppresses the write and retire
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            imem_rdata = 32'h0000_A103;
            imem_valid = imem_req;
            dmem_valid = dmem_req;
            #1;
            if (rf_we) seen = 1;
        end
        chk("wb_reached", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wb_reset_rf_we", 32'(rf_we), 32'd0);
        chk("wb_reset_retire", 32'(retire), 32'd0);
        @(negedge clk);
        chk("wb_reset_instret", instret, 32'd0);
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        rst_n = 1'b1;
        exp_instret = 32'd0;
        #1;
        chk("post_reset_idle_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("post_reset_fetch_req", 32'(imem_req), 32'd1);

        // Reset while a load is waiting on dmem_valid
        nreq = 0;
        for (int c = 0; c < 20 && nreq < 2; c++) begin
            @(negedge clk);
            imem_rdata = 32'h0000_A103;
            imem_valid = imem_req;
            dmem_valid = 1'b0;
            #1;
            if (dmem_req) nreq++;
        end
        chk("dmem_req_held", 32'(nreq), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_dmem_req", 32'(dmem_req), 32'd0);
        chk("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk_quiet("abort_outputs");
        @(negedge clk);
        imem_valid = 1'b0;
        rst_n = 1'b1;

        // Unsupported opcode halts
        nreq = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            imem_rdata = 32'h0000_12B7;     // lui
            imem_valid = imem_req;
            #1;
            if (c >= 2 && (imem_req || dmem_req || pc_we || rf_we)) nreq++;
        end
        chk("halt_quiet_cycles", 32'(nreq), 32'd0);
        chk("halt_illegal", 32'(illegal), 32'd1);
        chk("halt_inst", inst, 32'h0000_12B7);
        chk("halt_instret", instret, exp_instret);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
